// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one memory request/response channel
// between the committed-store drain and the speculative load path.
// Store priority with load anti-starvation, grant locking under
// backpressure, single outstanding load tracking with flush discard,
// and kseg0/kseg1 unmapped address translation.
module dmem_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic [3:0]        st_strobe,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_resp_valid,
   output logic [31:0]       ld_resp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [31:0]       mem_req_data,
   output logic [3:0]        mem_req_strobe,
   output logic              mem_req_wen,
   input  logic              mem_resp_valid,
   output logic              mem_resp_ready,
   input  logic [31:0]       mem_resp_data,
   output logic              busy
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_WAIT = 2'd1,
      LD_DROP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      LOCK_NONE = 2'd0,
      LOCK_ST   = 2'd1,
      LOCK_LD   = 2'd2
   } lock_t;

   state_t           state, state_nxt;
   lock_t            lock, lock_nxt;
   logic [CNT_W-1:0] starve_cnt, starve_nxt;

   logic              ld_eff;
   logic              grant_st, grant_ld;
   logic              hs_st, hs_ld;
   logic [ADDR_W-1:0] grant_vaddr;

   // kseg0 (0x8..0x9) and kseg1 (0xA..0xB) both map to physical 0x0..0x1FFF_FFFF;
   // both regions share top bits 2'b10, and the subtraction simply clears the top 3 bits.
   function automatic logic [ADDR_W-1:0] translate(input logic [ADDR_W-1:0] va);
      logic [ADDR_W-1:0] pa;
      pa = va;
      if (va[ADDR_W-1 -: 2] == 2'b10) pa[ADDR_W-1 -: 3] = 3'b000;
      return pa;
   endfunction

   assign ld_eff = ld_valid && !flush;
   assign hs_st  = grant_st && mem_req_ready;
   assign hs_ld  = grant_ld && mem_req_ready;

   // Grant selection: only in IDLE; a held lock overrides priority, a flushed locked load is dropped.
   always_comb begin
      // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
      grant_st = 1'b0;
      grant_ld = 1'b0;
      if (!rst && state == IDLE) begin
         case (lock)
            LOCK_ST: grant_st = 1'b1;
            LOCK_LD: grant_ld = !flush;
            default: begin
               if (st_valid && !(ld_eff && starve_cnt == CNT_MAX)) grant_st = 1'b1;
               else if (ld_eff)                                    grant_ld = 1'b1;
            end
         endcase
      end
   end

   // State, lock and starvation counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state      <= IDLE;
         lock       <= LOCK_NONE;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         lock       <= lock_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // Next-state logic for the outstanding-load tracker.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs_ld) state_nxt = LD_WAIT;
         LD_WAIT: begin
            if (mem_resp_valid) state_nxt = IDLE;
            else if (flush)     state_nxt = LD_DROP;
         end
         LD_DROP: if (mem_resp_valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Lock bookkeeping: hold an un-accepted grant, release on handshake or on flush of a locked load.
   always_comb begin
      lock_nxt = lock;
      if (state == IDLE) begin
         if (lock == LOCK_LD && flush) lock_nxt = LOCK_NONE;
         else if (hs_st || hs_ld)      lock_nxt = LOCK_NONE;
         else if (grant_st)            lock_nxt = LOCK_ST;
         else if (grant_ld)            lock_nxt = LOCK_LD;
      end
   end

   // Starvation counter: counts IDLE cycles a live load loses to a store, saturating at the limit.
   always_comb begin
      starve_nxt = starve_cnt;
      if (!ld_valid || flush || hs_ld)
         starve_nxt = '0;
      else if (state == IDLE && grant_st && starve_cnt != CNT_MAX)
         starve_nxt = starve_cnt + CNT_W'(1);
   end

   // Output decode: request mux from the granted requester, response gating by state and flush.
   always_comb begin
      grant_vaddr    = grant_ld ? ld_addr : st_addr;
      mem_req_valid  = grant_st || grant_ld;
      mem_req_addr   = mem_req_valid ? translate(grant_vaddr) : '0;
      mem_req_data   = grant_st ? st_data : 32'h0;
      mem_req_strobe = grant_st ? st_strobe : 4'h0;
      mem_req_wen    = grant_st;
      st_ready       = hs_st;
      ld_ready       = hs_ld;
      mem_resp_ready = !rst && (state != IDLE);
      ld_resp_valid  = !rst && (state == LD_WAIT) && mem_resp_valid && !flush;
      ld_resp_data   = ld_resp_valid ? mem_resp_data : 32'h0;
      busy           = !rst && (state != IDLE || lock != LOCK_NONE);
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter (STARVE_LIMIT = 2).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 time unit later, well clear of the next active edge.
module tb_dmem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [3:0]  st_strobe;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_addr;
   logic        ld_resp_valid;
   logic [31:0] ld_resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic [3:0]  mem_req_strobe;
   logic        mem_req_wen;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_resp_data;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   dmem_port_arbiter #(.STARVE_LIMIT(2), .ADDR_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .st_valid       (st_valid),
      .st_ready       (st_ready),
      .st_addr        (st_addr),
      .st_data        (st_data),
      .st_strobe      (st_strobe),
      .ld_valid       (ld_valid),
      .ld_ready       (ld_ready),
      .ld_addr        (ld_addr),
      .ld_resp_valid  (ld_resp_valid),
      .ld_resp_data   (ld_resp_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_data   (mem_req_data),
      .mem_req_strobe (mem_req_strobe),
      .mem_req_wen    (mem_req_wen),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp_data  (mem_resp_data),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      st_valid = 1'b1; st_addr = 32'h8000_0000; st_data = 32'h0; st_strobe = 4'hF;
      ld_valid = 1'b1; ld_addr = 32'h0000_0040;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;

      // Reset forces outputs low even with requests pending
      tick(); #1;
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_st_ready", st_ready, 0);
      check("rst_ld_ready", ld_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_resp_ready", mem_resp_ready, 0);
      tick();
      rst = 1'b0; st_valid = 1'b0; ld_valid = 1'b0; #1;
      check("post_rst_state", dut.state, S_IDLE);
      check("post_rst_req_valid", mem_req_valid, 0);

      // Store only, kseg0 address
      st_valid = 1'b1; st_addr = 32'h8000_0010; st_data = 32'h1122_3344; st_strobe = 4'b0001;
      #1;
      check("st_req_valid", mem_req_valid, 1);
      check("st_addr", mem_req_addr, 32'h0000_0010);
      check("st_wen", mem_req_wen, 1);
      check("st_ready", st_ready, 1);
      check("st_data", mem_req_data, 32'h1122_3344);
      check("st_strobe", mem_req_strobe, 4'b0001);
      tick();
      st_valid = 1'b0; #1;
      check("st_state_idle", dut.state, S_IDLE);
      check("st_busy", busy, 0);

      // Load round trip, kseg1 address, response 3 cycles after accept
      ld_valid = 1'b1; ld_addr = 32'hA000_0100; #1;
      check("ld_addr", mem_req_addr, 32'h0000_0100);
      check("ld_ready", ld_ready, 1);
      check("ld_wen", mem_req_wen, 0);
      check("ld_strobe", mem_req_strobe, 0);
      tick();
      ld_valid = 1'b0; st_valid = 1'b1; st_addr = 32'h0000_0800; #1;
      check("ld_wait_state", dut.state, S_WAIT);
      check("ld_wait_busy", busy, 1);
      check("ld_wait_store_blocked", mem_req_valid, 0);
      check("ld_wait_st_ready", st_ready, 0);
      check("ld_wait_resp_ready", mem_resp_ready, 1);
      check("ld_wait_no_resp1", ld_resp_valid, 0);
      tick();
      st_valid = 1'b0; #1;
      check("ld_wait_no_resp2", ld_resp_valid, 0);
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF; #1;
      check("ld_resp_valid", ld_resp_valid, 1);
      check("ld_resp_data", ld_resp_data, 32'hDEAD_BEEF);
      tick();
      mem_resp_valid = 1'b0; #1;
      check("ld_back_idle", dut.state, S_IDLE);
      check("ld_resp_pulse_end", ld_resp_valid, 0);

      // Starvation with limit 2: store, store, load
      st_valid = 1'b1; st_addr = 32'h0000_1000; st_data = 32'h0BAD_F00D; st_strobe = 4'hF;
      ld_valid = 1'b1; ld_addr = 32'h9000_0040; #1;
      check("starve_g1_wen", mem_req_wen, 1);
      check("starve_g1_st_ready", st_ready, 1);
      check("starve_g1_addr", mem_req_addr, 32'h0000_1000);
      tick(); #1;
      check("starve_g2_wen", mem_req_wen, 1);
      check("starve_g2_ld_ready", ld_ready, 0);
      tick(); #1;
      check("starve_g3_wen", mem_req_wen, 0);
      check("starve_g3_ld_ready", ld_ready, 1);
      check("starve_g3_st_ready", st_ready, 0);
      check("starve_g3_addr", mem_req_addr, 32'h1000_0040);
      tick();
      st_valid = 1'b0; ld_valid = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678; #1;
      check("starve_resp_data", ld_resp_data, 32'h1234_5678);
      tick();
      mem_resp_valid = 1'b0; #1;

      // Flush in the cycle after load accept; response 2 cycles later is dropped
      ld_valid = 1'b1; ld_addr = 32'h0000_0200; #1;
      check("fl_ld_ready", ld_ready, 1);
      check("fl_ld_addr", mem_req_addr, 32'h0000_0200);
      tick();
      ld_valid = 1'b0; flush = 1'b1; #1;
      check("fl_state_wait", dut.state, S_WAIT);
      check("fl_no_resp_a", ld_resp_valid, 0);
      tick();
      #1;
      check("fl_state_drop", dut.state, S_DROP);
      check("fl_drop_resp_ready", mem_resp_ready, 1);
      tick();
      flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D; #1;
      check("fl_drop_after_2nd_flush", dut.state, S_DROP);
      check("fl_no_resp_b", ld_resp_valid, 0);
      tick();
      mem_resp_valid = 1'b0; #1;
      check("fl_back_idle", dut.state, S_IDLE);
      check("fl_busy", busy, 0);

      // Response and flush in the same LD_WAIT cycle: discarded, back to IDLE
      ld_valid = 1'b1; ld_addr = 32'h0000_0204; #1;
      check("fr_ld_ready", ld_ready, 1);
      tick();
      ld_valid = 1'b0; flush = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0055; #1;
      check("fr_no_resp", ld_resp_valid, 0);
      tick();
      flush = 1'b0; mem_resp_valid = 1'b0; #1;
      check("fr_back_idle", dut.state, S_IDLE);

      // Locked store under backpressure, load arrives, then flush
      mem_req_ready = 1'b0;
      st_valid = 1'b1; st_addr = 32'hBFFF_FFF0; st_data = 32'hA5A5_5A5A; st_strobe = 4'b1100; #1;
      check("lk_c1_valid", mem_req_valid, 1);
      check("lk_c1_st_ready", st_ready, 0);
      check("lk_c1_addr", mem_req_addr, 32'h1FFF_FFF0);
      tick();
      ld_valid = 1'b1; ld_addr = 32'h0000_0300; #1;
      check("lk_c2_busy", busy, 1);
      check("lk_c2_wen", mem_req_wen, 1);
      check("lk_c2_addr", mem_req_addr, 32'h1FFF_FFF0);
      check("lk_c2_data", mem_req_data, 32'hA5A5_5A5A);
      check("lk_c2_strobe", mem_req_strobe, 4'b1100);
      tick(); #1;
      check("lk_c3_wen", mem_req_wen, 1);
      check("lk_c3_addr", mem_req_addr, 32'h1FFF_FFF0);
      tick();
      flush = 1'b1; mem_req_ready = 1'b1; #1;
      check("lk_flush_st_ready", st_ready, 1);
      check("lk_flush_wen", mem_req_wen, 1);
      check("lk_flush_data", mem_req_data, 32'hA5A5_5A5A);
      check("lk_flush_ld_ready", ld_ready, 0);
      tick();
      flush = 1'b0; st_valid = 1'b0; ld_valid = 1'b0; #1;
      check("lk_done_valid", mem_req_valid, 0);
      check("lk_done_busy", busy, 0);
      check("lk_done_state", dut.state, S_IDLE);

      // Locked load holds over a later store, then is killed by flush
      mem_req_ready = 1'b0;
      ld_valid = 1'b1; ld_addr = 32'h0000_0400; #1;
      check("ll_c1_valid", mem_req_valid, 1);
      check("ll_c1_wen", mem_req_wen, 0);
      tick();
      st_valid = 1'b1; st_addr = 32'h0000_0500; #1;
      check("ll_c2_busy", busy, 1);
      check("ll_c2_wen", mem_req_wen, 0);
      check("ll_c2_addr", mem_req_addr, 32'h0000_0400);
      tick();
      st_valid = 1'b0; flush = 1'b1; #1;
      check("ll_flush_valid", mem_req_valid, 0);
      check("ll_flush_ld_ready", ld_ready, 0);
      tick();
      flush = 1'b0; ld_valid = 1'b0; #1;
      check("ll_done_busy", busy, 0);
      check("ll_done_state", dut.state, S_IDLE);

      // Reset while a load is outstanding: response abandoned
      mem_req_ready = 1'b1;
      ld_valid = 1'b1; ld_addr = 32'h0000_0600; #1;
      check("rw_ld_ready", ld_ready, 1);
      tick();
      ld_valid = 1'b0; #1;
      check("rw_state_wait", dut.state, S_WAIT);
      rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0077; #1;
      check("rw_rst_resp_valid", ld_resp_valid, 0);
      check("rw_rst_resp_ready", mem_resp_ready, 0);
      tick();
      rst = 1'b0; mem_resp_valid = 1'b0; #1;
      check("rw_state_idle", dut.state, S_IDLE);
      check("rw_busy", busy, 0);
      check("rw_req_valid", mem_req_valid, 0);
      check("rw_resp_ready", mem_resp_ready, 0);
      check("rw_resp_valid", ld_resp_valid, 0);
      check("rw_resp_data", ld_resp_data, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
